// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with FWFT/standard read mode, programmable
// watermarks, synchronous flush and sticky overflow/underflow flags.
//
// Ports:
//   i_clk, i_rstn (sync, active-low), i_flush (sync clear)
//   write side: i_wr, i_data, o_full, o_almost_full, o_overflow
//   read side : i_rd, o_data, o_valid, o_empty, o_almost_empty,
//               o_underflow
//   i_af_thresh / i_ae_thresh: watermarks; o_fill: current word count
module sync_fifo_prog #(
  parameter int DW   = 8,
  parameter int AW   = 4,
  parameter bit FWFT = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_flush,
  input  logic          i_wr,
  input  logic [DW-1:0] i_data,
  output logic          o_full,
  output logic          o_almost_full,
  output logic          o_overflow,
  input  logic          i_rd,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_empty,
  output logic          o_almost_empty,
  output logic          o_underflow,
  input  logic [AW:0]   i_af_thresh,
  input  logic [AW:0]   i_ae_thresh,
  output logic [AW:0]   o_fill
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  // Next memory word to fetch into the output register.
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] fill_q, fill_d;
  logic        valid_q, valid_d;
  logic        empty_q, empty_d;
  logic        full_q, full_d;
  logic        af_q, af_d;
  logic        ae_q, ae_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [DW-1:0] data_q;

  logic wr_acc;
  logic rd_acc;
  logic load;

  always_comb begin
    wr_acc = i_wr && !full_q && !i_flush;
    rd_acc = 1'b0;
    load   = 1'b0;
    if (FWFT) begin
      rd_acc = i_rd && !i_flush && valid_q;
      // Refill the output register whenever it is free or being
      // popped and memory still holds an unfetched word.
      load = !i_flush && (!valid_q || rd_acc) &&
             (wr_ptr_q != rd_ptr_q);
    end else begin
      rd_acc = i_rd && !i_flush && !empty_q;
      load   = rd_acc;
    end

    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_acc);
    rd_ptr_d = rd_ptr_q + (AW+1)'(load);
    fill_d   = fill_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    if (FWFT) valid_d = load || (valid_q && !rd_acc);
    else      valid_d = load;
    ovf_d = ovf_q | (i_wr & full_q);
    unf_d = unf_q | (i_rd & !rd_acc);

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end

    empty_d = (fill_d == '0);
    full_d  = (fill_d == FULL_CNT);
    af_d    = (fill_d >= i_af_thresh);
    ae_d    = (fill_d <= i_ae_thresh);
    if (i_flush) begin
      af_d = 1'b0;
      ae_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) data_q <= '0;
    else if (load) data_q <= mem[rd_ptr_q[AW-1:0]];
  end

  assign o_full         = full_q;
  assign o_almost_full  = af_q;
  assign o_overflow     = ovf_q;
  assign o_data         = data_q;
  assign o_valid        = valid_q;
  assign o_empty        = empty_q;
  assign o_almost_empty = ae_q;
  assign o_underflow    = unf_q;
  assign o_fill         = fill_q;

endmodule
